uart_rx_param: RTL and testbench

Parametrised UART receive engine, successor to the fixed 8N1 receiver. Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. Uses 16x (configurable) oversampling with 3-sample majority voting, validates the start bit, and reports parity, framing and break conditions alongside each received character. Sits between the board RXD pin and the command/loopback logic; its uart_done/data interface is compatible with the existing receiver.

---
 rtl/uart_rx_param.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with oversampled 3-sample majority voting and
// parity/framing/break reporting on each uart_done pulse.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 uart_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int TICK_DIV = CLK_FREQ / (UART_BPS * OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]  IDX_S0   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  IDX_S1   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  IDX_S2   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  IDX_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STP_LAST = 1'(STOP_BITS - 1);

    if (TICK_DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0)
    begin : g_bad_params
        $error("uart_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE, ST_WAIT_IDLE
    } state_t;

    state_t                 state, state_nxt;
    logic                   sync1, sync2, sync3;
    logic [DIV_W-1:0]       div_cnt;
    logic [OS_W-1:0]        tick_idx;
    logic                   v0, v1;
    logic [DATA_BITS-1:0]   shreg;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   par_bit;
    logic                   ferr_acc;

    logic rx_s, start_edge, tick, vote_stb, bit_end, vote, par_x;

    assign rx_s       = sync2;
    assign start_edge = sync3 & ~sync2;
    assign tick       = (div_cnt == DIV_LAST);
    assign vote_stb   = tick && (tick_idx == IDX_S2);
    assign bit_end    = tick && (tick_idx == IDX_LAST);
    assign vote       = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign par_x      = (^shreg) ^ par_bit;

    // Two-stage synchroniser plus edge-detect flop, idle-high at reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Oversample tick divider and in-bit tick index, parked at 0 outside a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tick_idx <= '0;
        end else if (state == ST_IDLE || state == ST_DONE || state == ST_WAIT_IDLE) begin
            div_cnt  <= '0;
            tick_idx <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_idx <= (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start_edge) state_nxt = ST_START;
            ST_START: begin
                if (vote_stb && vote) state_nxt = ST_IDLE;
                else if (bit_end)     state_nxt = ST_DATA;
            end
            ST_DATA:      if (bit_end && bit_cnt == BIT_LAST)
                              state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (bit_end) state_nxt = ST_STOP;
            // Leave on the final stop vote so a back-to-back start edge is seen in IDLE
            ST_STOP:      if (vote_stb && stop_cnt == STP_LAST) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ferr_acc ? ST_WAIT_IDLE : ST_IDLE;
            ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Sampling, shifting, error accumulation and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0         <= 1'b0;
            v1         <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            data       <= '0;
            uart_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            busy      <= (state_nxt != ST_IDLE);
            if (tick && tick_idx == IDX_S0) v0 <= rx_s;
            if (tick && tick_idx == IDX_S1) v1 <= rx_s;
            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    par_bit  <= 1'b0;
                    ferr_acc <= 1'b0;
                end
                ST_DATA: begin
                    if (vote_stb) shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    if (bit_end)  bit_cnt <= bit_cnt + 1'b1;
                end
                ST_PARITY: if (vote_stb) par_bit <= vote;
                ST_STOP: begin
                    if (vote_stb && !vote) ferr_acc <= 1'b1;
                    if (bit_end)           stop_cnt <= 1'b1;
                end
                ST_DONE: begin
                    data       <= shreg;
                    uart_done  <= 1'b1;
                    frame_err  <= ferr_acc;
                    parity_err <= (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;
                    break_det  <= (shreg == '0) && (par_bit == 1'b0) && ferr_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of uart_rx_param in 8N1 and 7E2 setups.
module tb_uart_rx_param;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       done_a, pe_a, fe_a, bd_a, busy_a;
    logic       done_b, pe_b, fe_b, bd_b, busy_b;

    int checks = 0;
    int errors = 0;

    logic [11:0] q_a[$];
    logic [11:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(3200000), .UART_BPS(100000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
    ) dut_a (
        .clk(clk), .rst(rst), .uart_rxd(rxd_a), .data(data_a), .uart_done(done_a),
        .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ(3200000), .UART_BPS(100000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16)
    ) dut_b (
        .clk(clk), .rst(rst), .uart_rxd(rxd_b), .data(data_b), .uart_done(done_b),
        .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b), .busy(busy_b)
    );

    // Record each completed frame as {break, frame_err, parity_err, data}
    always @(negedge clk) begin
        if (done_a) q_a.push_back({bd_a, fe_a, pe_a, 1'b0, data_a});
        if (done_b) q_b.push_back({bd_b, fe_b, pe_b, 2'b00, data_b});
    end

    task automatic drive_bit(input bit sel_b, input logic v, input bit glitch);
        logic lv;
        for (int c = 0; c < BIT_CLK; c++) begin
            lv = v;
            if (glitch && v && (c == 18 || c == 19)) lv = 1'b0;
            if (sel_b) rxd_b = lv;
            else       rxd_a = lv;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit sel_b, input logic [8:0] d, input int nb,
                              input bit has_par, input logic pbit, input int ns,
                              input bit glitch);
        drive_bit(sel_b, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(sel_b, d[i], glitch);
        if (has_par) drive_bit(sel_b, pbit, glitch);
        for (int i = 0; i < ns; i++) drive_bit(sel_b, 1'b1, glitch);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        checks++;
        if ({data_a, done_a, pe_a, fe_a, bd_a, busy_a} !== 13'h0) begin
            errors++;
            $display("FAIL reset_a: got %h required 0", {data_a, done_a, pe_a, fe_a, bd_a, busy_a});
        end
        checks++;
        if ({data_b, done_b, pe_b, fe_b, bd_b, busy_b} !== 12'h0) begin
            errors++;
            $display("FAIL reset_b: got %h required 0", {data_b, done_b, pe_b, fe_b, bd_b, busy_b});
        end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_back_to_back;
        q_a.delete();
        send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0);
        send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++;
        if (q_a.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 2", q_a.size());
        end else begin
            checks++;
            if (q_a[0] !== 12'h0A5) begin
                errors++;
                $display("FAIL b2b_first: got %h required 0a5", q_a[0]);
            end
            checks++;
            if (q_a[1] !== 12'h03C) begin
                errors++;
                $display("FAIL b2b_second: got %h required 03c", q_a[1]);
            end
        end
    endtask

    task automatic test_parity;
        q_b.delete();
        send_frame(1'b1, 9'h055, 7, 1'b1, 1'b0, 2, 1'b0);
        idle_bits(1);
        send_frame(1'b1, 9'h055, 7, 1'b1, 1'b1, 2, 1'b0);
        idle_bits(2);
        checks++;
        if (q_b.size() !== 2) begin
            errors++;
            $display("FAIL par_count: got %0d required 2", q_b.size());
        end else begin
            checks++;
            if (q_b[0] !== 12'h055) begin
                errors++;
                $display("FAIL par_good: got %h required 055", q_b[0]);
            end
            checks++;
            if (q_b[1] !== 12'h255) begin
                errors++;
                $display("FAIL par_bad: got %h required 255", q_b[1]);
            end
        end
    endtask

    task automatic test_start_glitch;
        q_a.delete();
        rxd_a = 1'b0;
        repeat (6) @(negedge clk);
        rxd_a = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_hi: got %b required 1", busy_a);
        end
        repeat (BIT_CLK - 10) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_lo: got %b required 0", busy_a);
        end
        idle_bits(1);
        checks++;
        if (q_a.size() !== 0) begin
            errors++;
            $display("FAIL glitch_no_done: got %0d required 0", q_a.size());
        end
        send_frame(1'b0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++;
        if (q_a.size() !== 1 || q_a[0] !== 12'h081) begin
            errors++;
            $display("FAIL glitch_next: got n=%0d %h required n=1 081", q_a.size(), q_a.size() ? q_a[0] : 12'h0);
        end
    endtask

    task automatic test_majority;
        q_a.delete();
        send_frame(1'b0, 9'h00F, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(2);
        checks++;
        if (q_a.size() !== 1 || q_a[0] !== 12'h00F) begin
            errors++;
            $display("FAIL majority: got n=%0d %h required n=1 00f", q_a.size(), q_a.size() ? q_a[0] : 12'h0);
        end
    endtask

    task automatic test_break;
        q_a.delete();
        rxd_a = 1'b0;
        idle_bits(30);
        checks++;
        if (q_a.size() !== 1 || q_a[0] !== 12'hC00) begin
            errors++;
            $display("FAIL break_frame: got n=%0d %h required n=1 c00", q_a.size(), q_a.size() ? q_a[0] : 12'h0);
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL break_wait_busy: got %b required 1", busy_a);
        end
        rxd_a = 1'b1;
        idle_bits(2);
        send_frame(1'b0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++;
        if (q_a.size() !== 2) begin
            errors++;
            $display("FAIL break_count: got %0d required 2", q_a.size());
        end else begin
            checks++;
            if (q_a[1] !== 12'h07E) begin
                errors++;
                $display("FAIL break_next: got %h required 07e", q_a[1]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] c3;
        q_a.delete();
        c3 = 8'hC3;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, c3[i], 1'b0);
        rxd_a = c3[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_before: got %b required 1", busy_a);
        end
        rst   = 1'b1;
        rxd_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_a, done_a, pe_a, fe_a, bd_a, busy_a} !== 13'h0) begin
            errors++;
            $display("FAIL rst_outputs: got %h required 0", {data_a, done_a, pe_a, fe_a, bd_a, busy_a});
        end
        rst = 1'b0;
        idle_bits(2);
        send_frame(1'b0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++;
        if (q_a.size() !== 1 || q_a[0] !== 12'h012) begin
            errors++;
            $display("FAIL rst_next: got n=%0d %h required n=1 012", q_a.size(), q_a.size() ? q_a[0] : 12'h0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_parity();
        test_start_glitch();
        test_majority();
        test_break();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
